// File: rtl/fdl_pkg.sv
// Shared types and helpers for the fine delay line controller.
package fdl_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} ctrl_state_e;
  typedef enum logic {DIR_DN, DIR_UP} dir_e;

  // Widest thermometer therm_encode can build; callers keep the low N bits.
  localparam int unsigned THERM_MAX = 256;

  function automatic logic [THERM_MAX-1:0] therm_encode(input int unsigned code,
                                                        input int unsigned n);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < THERM_MAX; k++) begin
      if (k < n && k < code) t[k] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/fdl_vote_filter.sv
// Bang-bang vote integrator: decodes PD votes into a signed accumulator and
// emits a single-cycle step request when the net count reaches +/-th.
module fdl_vote_filter #(
  parameter int AW = 5
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          active,
  input  logic          pd_valid,
  input  logic          pd_up,
  input  logic          pd_dn,
  input  logic [AW-1:0] th,
  output logic          step_up,
  output logic          step_dn
);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] vote;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] th_s;

  always_comb begin
    vote = '0;
    if (pd_valid && pd_up && !pd_dn) vote = AW'(1);
    else if (pd_valid && pd_dn && !pd_up) vote = '1;
    th_s     = $signed(th);
    acc_next = acc + vote;
    step_up  = active && (acc_next >= th_s);
    step_dn  = active && (acc_next <= -th_s);
  end

  // Inactive covers IDLE, en low and force_load: the accumulator restarts at 0.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!active || step_up || step_dn) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/fdl_ctrl.sv
// Fine delay line controller: filtered single-stage thermometer stepping with
// complementary T/Tb drive, saturation carry/borrow and reversal-based lock.
module fdl_ctrl
  import fdl_pkg::*;
#(
  parameter  int N_STAGE      = 8,
  parameter  int FILT_TH      = 4,
  parameter  int FILT_TH_LOCK = 8,
  parameter  int LOCK_REV     = 4,
  localparam int CW           = $clog2(N_STAGE + 1)
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               en,
  input  logic               pd_valid,
  input  logic               pd_up,
  input  logic               pd_dn,
  input  logic               force_load,
  input  logic [CW-1:0]      force_code,
  output logic [N_STAGE-1:0] T,
  output logic [N_STAGE-1:0] Tb,
  output logic [CW-1:0]      code,
  output logic               locked,
  output logic               sat_hi,
  output logic               sat_lo,
  output logic               carry_req,
  output logic               borrow_req
);

  localparam int AW = $clog2(FILT_TH_LOCK) + 2;
  localparam int RW = $clog2(LOCK_REV + 1);
  localparam logic [CW-1:0] CODE_MAX = CW'(N_STAGE);
  localparam logic [CW-1:0] CODE_MID = CW'(N_STAGE / 2);
  localparam logic [RW-1:0] REV_MAX  = RW'(LOCK_REV);
  localparam logic [THERM_MAX-1:0] MID_THERM = therm_encode(N_STAGE / 2, N_STAGE);

  ctrl_state_e state, state_next;
  dir_e        last_dir, dir_next, step_dir;
  logic [CW-1:0] code_q, code_next;
  logic [RW-1:0] rev_cnt, rev_next;
  logic          carry_next, borrow_next;
  logic          active, step_up, step_dn, step, hit_hi, hit_lo;
  logic [AW-1:0] th;
  logic [THERM_MAX-1:0] therm_full;
  logic [N_STAGE-1:0]   t_next;
  logic                 therm_unused;

  assign active = en && !force_load && (state != IDLE);
  assign th     = (state == LOCKED) ? AW'(FILT_TH_LOCK) : AW'(FILT_TH);

  fdl_vote_filter #(.AW(AW)) u_filter (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .active   (active),
    .pd_valid (pd_valid),
    .pd_up    (pd_up),
    .pd_dn    (pd_dn),
    .th       (th),
    .step_up  (step_up),
    .step_dn  (step_dn)
  );

  assign step     = step_up || step_dn;
  assign step_dir = step_up ? DIR_UP : DIR_DN;
  assign hit_hi   = step_up && (code_q == CODE_MAX);
  assign hit_lo   = step_dn && (code_q == '0);

  always_comb begin
    state_next  = state;
    code_next   = code_q;
    rev_next    = rev_cnt;
    dir_next    = last_dir;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (force_load) begin
      code_next  = (force_code > CODE_MAX) ? CODE_MAX : force_code;
      rev_next   = '0;
      state_next = en ? ACQ : IDLE;
    end else if (!en) begin
      rev_next   = '0;
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: state_next = ACQ;
        ACQ, LOCKED: begin
          if (step) begin
            dir_next    = step_dir;
            carry_next  = hit_hi;
            borrow_next = hit_lo;
            if (step_up && !hit_hi) code_next = code_q + 1'b1;
            if (step_dn && !hit_lo) code_next = code_q - 1'b1;
            if (step_dir == last_dir) rev_next = '0;
            else if (rev_cnt != REV_MAX) rev_next = rev_cnt + 1'b1;
            if (state == ACQ) begin
              if (rev_next == REV_MAX) state_next = LOCKED;
            end else if (step_dir == last_dir || hit_hi || hit_lo) begin
              state_next = ACQ;
              rev_next   = '0;
            end
          end
        end
      endcase
    end
  end

  // T/Tb are registered from the next code so the cell drive never sees decode glitches.
  assign therm_full   = therm_encode(32'(code_next), N_STAGE);
  assign t_next       = therm_full[N_STAGE-1:0];
  assign therm_unused = ^therm_full;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_q     <= CODE_MID;
      rev_cnt    <= '0;
      last_dir   <= DIR_UP;
      carry_req  <= 1'b0;
      borrow_req <= 1'b0;
      T          <= MID_THERM[N_STAGE-1:0];
      Tb         <= ~MID_THERM[N_STAGE-1:0];
    end else begin
      state      <= state_next;
      code_q     <= code_next;
      rev_cnt    <= rev_next;
      last_dir   <= dir_next;
      carry_req  <= carry_next;
      borrow_req <= borrow_next;
      T          <= t_next;
      Tb         <= ~t_next;
    end
  end

  assign code   = code_q;
  assign locked = (state == LOCKED);
  assign sat_hi = (code_q == CODE_MAX);
  assign sat_lo = (code_q == '0);

endmodule

// File: tb/tb_fdl_ctrl.sv
// Directed plus random bench for fdl_ctrl with a cycle-accurate scoreboard model.
module tb_fdl_ctrl;

  localparam int N  = 8;
  localparam int TH = 4;
  localparam int TL = 8;
  localparam int LR = 4;

  logic       clk_in = 1'b0;
  logic       rst_n, en, pd_valid, pd_up, pd_dn, force_load;
  logic [3:0] force_code;
  logic [7:0] T, Tb;
  logic [3:0] code;
  logic       locked, sat_hi, sat_lo, carry_req, borrow_req;

  fdl_ctrl #(.N_STAGE(N), .FILT_TH(TH), .FILT_TH_LOCK(TL), .LOCK_REV(LR)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .en         (en),
    .pd_valid   (pd_valid),
    .pd_up      (pd_up),
    .pd_dn      (pd_dn),
    .force_load (force_load),
    .force_code (force_code),
    .T          (T),
    .Tb         (Tb),
    .code       (code),
    .locked     (locked),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo),
    .carry_req  (carry_req),
    .borrow_req (borrow_req)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] t;
    logic [7:0] tb;
    logic       locked, sat_hi, sat_lo, carry, borrow;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: 0=IDLE 1=ACQ 2=LOCKED, dir 1=up 0=down.
  int m_code, m_acc, m_rev, m_state, m_dir, m_carry, m_borrow;
  logic en_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] therm8(input int c);
    logic [7:0] t;
    t = '0;
    for (int k = 0; k < 8; k++) if (k < c) t[k] = 1'b1;
    return t;
  endfunction

  task automatic model_step(input logic v, input logic u, input logic d, input logic fl,
                            input logic [3:0] fc, input logic e, input logic rs);
    int thr, vote, an, dir;
    bit same;
    m_carry  = 0;
    m_borrow = 0;
    if (!rs) begin
      m_code = N / 2; m_acc = 0; m_rev = 0; m_state = 0; m_dir = 1;
    end else if (fl) begin
      m_code = (int'(fc) > N) ? N : int'(fc);
      m_acc = 0; m_rev = 0; m_state = e ? 1 : 0;
    end else if (!e) begin
      m_acc = 0; m_rev = 0; m_state = 0;
    end else if (m_state == 0) begin
      m_acc = 0; m_state = 1;
    end else begin
      thr  = (m_state == 2) ? TL : TH;
      vote = (v && u && !d) ? 1 : (v && d && !u) ? -1 : 0;
      an   = m_acc + vote;
      if (an >= thr || an <= -thr) begin
        m_acc = 0;
        dir   = (an > 0) ? 1 : 0;
        if (dir == 1) begin
          if (m_code == N) m_carry = 1; else m_code++;
        end else begin
          if (m_code == 0) m_borrow = 1; else m_code--;
        end
        same = (dir == m_dir);
        if (same) m_rev = 0;
        else if (m_rev < LR) m_rev++;
        m_dir = dir;
        if (m_state == 1) begin
          if (m_rev == LR) m_state = 2;
        end else if (same || m_carry != 0 || m_borrow != 0) begin
          m_state = 1; m_rev = 0;
        end
      end else begin
        m_acc = an;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic u, input logic d, input logic fl,
                       input logic [3:0] fc, input logic e, input logic rs);
    exp_t x, got;
    rst_n = rs; en = e; pd_valid = v; pd_up = u; pd_dn = d;
    force_load = fl; force_code = fc;
    model_step(v, u, d, fl, fc, e, rs);
    x.code   = 4'(m_code);
    x.t      = therm8(m_code);
    x.tb     = ~therm8(m_code);
    x.locked = (m_state == 2);
    x.sat_hi = (m_code == N);
    x.sat_lo = (m_code == 0);
    x.carry  = (m_carry != 0);
    x.borrow = (m_borrow != 0);
    exp_q.push_back(x);
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("code", 32'(code), 32'(got.code));
      check("T", 32'(T), 32'(got.t));
      check("Tb", 32'(Tb), 32'(got.tb));
      check("locked", 32'(locked), 32'(got.locked));
      check("sat_hi", 32'(sat_hi), 32'(got.sat_hi));
      check("sat_lo", 32'(sat_lo), 32'(got.sat_lo));
      check("carry_req", 32'(carry_req), 32'(got.carry));
      check("borrow_req", 32'(borrow_req), 32'(got.borrow));
    end
  endtask

  task automatic votes(input int n, input logic u, input logic d);
    for (int i = 0; i < n; i++) cycle(1'b1, u, d, 1'b0, 4'd0, en_r, 1'b1);
  endtask

  task automatic load(input logic [3:0] fc);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, fc, en_r, 1'b1);
  endtask

  initial begin
    en_r = 1'b0;
    rst_n = 1'b0; en = 1'b0; pd_valid = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
    force_load = 1'b0; force_code = '0;

    // Reset state
    cycle(0, 0, 0, 0, 4'd0, 0, 0);
    cycle(0, 0, 0, 0, 4'd0, 0, 0);
    check("rst_code", 32'(code), 32'd4);
    check("rst_T", 32'(T), 32'h0F);
    check("rst_Tb", 32'(Tb), 32'hF0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_sat", 32'({sat_hi, sat_lo}), 32'd0);

    // Enable, then one step up after four votes
    en_r = 1'b1;
    cycle(0, 0, 0, 0, 4'd0, 1, 1);
    votes(3, 1, 0);
    check("pre_step_code", 32'(code), 32'd4);
    votes(1, 1, 0);
    check("step_code", 32'(code), 32'd5);
    check("step_T", 32'(T), 32'h1F);
    votes(3, 1, 0);
    check("no_step_code", 32'(code), 32'd5);

    // Upper saturation: carry pulse
    load(4'd8);
    votes(3, 1, 0);
    check("carry_early", 32'(carry_req), 32'd0);
    votes(1, 1, 0);
    check("carry_pulse", 32'(carry_req), 32'd1);
    check("carry_code", 32'(code), 32'd8);
    check("carry_sat_hi", 32'(sat_hi), 32'd1);
    cycle(0, 0, 0, 0, 4'd0, 1, 1);
    check("carry_drop", 32'(carry_req), 32'd0);

    // Lower saturation: borrow pulse
    load(4'd0);
    votes(4, 0, 1);
    check("borrow_pulse", 32'(borrow_req), 32'd1);
    check("borrow_sat_lo", 32'(sat_lo), 32'd1);
    cycle(0, 0, 0, 0, 4'd0, 1, 1);
    check("borrow_drop", 32'(borrow_req), 32'd0);

    // Four reversals to lock
    load(4'd4);
    votes(4, 1, 0);
    votes(4, 0, 1);
    votes(4, 1, 0);
    check("not_locked_yet", 32'(locked), 32'd0);
    votes(4, 0, 1);
    check("locked", 32'(locked), 32'd1);
    votes(4, 1, 0);
    check("lock_th_hold", 32'(code), 32'd4);
    votes(4, 1, 0);
    check("lock_th_step", 32'(code), 32'd5);
    check("still_locked", 32'(locked), 32'd1);
    votes(8, 1, 0);
    check("unlock_code", 32'(code), 32'd6);
    check("unlocked", 32'(locked), 32'd0);

    // Conflicting votes are neutral
    votes(20, 1, 1);
    check("conflict_code", 32'(code), 32'd6);

    // Forced load clamps to N_STAGE
    load(4'd12);
    check("force_code", 32'(code), 32'd8);
    check("force_T", 32'(T), 32'hFF);

    // en drop mid-burst clears the accumulator
    votes(2, 0, 1);
    en_r = 1'b0;
    votes(5, 0, 1);
    check("en_off_code", 32'(code), 32'd8);
    en_r = 1'b1;
    votes(1, 0, 1);
    votes(3, 0, 1);
    check("acc_cleared", 32'(code), 32'd8);
    votes(1, 0, 1);
    check("resume_step", 32'(code), 32'd7);

    // Random vote stream
    for (int i = 0; i < 10000; i++) begin
      logic v, u, d, fl, rs;
      logic [3:0] fc;
      int prev, dc;
      v  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 199) == 0);
      fc = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 2999) != 0);
      en_r = ($urandom_range(0, 49) != 0);
      prev = m_code;
      cycle(v, u, d, fl, fc, en_r, rs);
      dc = int'(code) - prev;
      check("rand_dcode", 32'((dc >= -1 && dc <= 1) || fl || !rs), 32'd1);
      check("rand_popT", 32'($countones(T)), 32'(m_code));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
